push_pop_sequencer: RTL and testbench
=====================================

PUSH_POP_SEQUENCER -- requirements
Module: push_pop_sequencer

Interface
REQ-001 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have port rst_n_i, input, 1, an asynchronous active-low reset.
REQ-003 The block SHALL have port instr_i, input, 16, the instruction presented by decode.
REQ-004 The block SHALL have port instr_valid_i, input, 1, qualifying instr_i.
REQ-005 The block SHALL have port uop_ready_i, input, 1, meaning the datapath accepts the current micro-op.
REQ-006 The block SHALL have port flush_i, input, 1, a synchronous abort (branch/pipeline flush).
REQ-007 The block SHALL have port stall_o, output, 1, holding fetch/decode while a sequence is in progress.
REQ-008 The block SHALL have port uop_valid_o, output, 1, meaning a micro-op is presented.
REQ-009 The block SHALL have port uop_load_o, output, 1, marking a memory-to-register beat (POP).
REQ-010 The block SHALL have port uop_store_o, output, 1, marking a register-to-memory beat (PUSH).
REQ-011 The block SHALL have port uop_reg_o, output, 4, the register transferred (0-7, 14=LR, 15=PC).
REQ-012 The block SHALL have port sp_dec_o, output, 1, meaning SP is decremented by 4 (pre-decrement) with this beat.
REQ-013 The block SHALL have port sp_inc_o, output, 1, meaning SP is incremented by 4 (post-increment) with this beat.
REQ-014 The block SHALL have port done_o, output, 1, a one-cycle pulse when a sequence completes normally.

Function
REQ-015 The block SHALL treat an instruction as push/pop when instr_valid_i=1, instr_i[15:12]=4'b1011 and instr_i[10:9]=2'b10. In that encoding, L=instr_i[11] (1=POP), R=instr_i[8], and the register list is instr_i[7:0].
REQ-016 The block SHALL have three states, IDLE, ISSUE and DONE, and SHALL reset to IDLE.
REQ-017 In IDLE, on a push/pop the block SHALL latch L and a 9-bit pending mask {R, list}. The next state SHALL be ISSUE if the mask is non-zero, else DONE.
REQ-018 The block SHALL ignore instructions that are not push/pop and SHALL leave all outputs at 0 for them.
REQ-019 stall_o SHALL be combinationally 1 in IDLE when a push/pop is presented, and SHALL be 1 throughout ISSUE and DONE.
REQ-020 The first uop_valid_o SHALL occur in the cycle after acceptance (1-cycle latency).
REQ-021 PUSH order SHALL be descending: LR (mask bit 8) first, then R7 down to R0. uop_store_o=1 and sp_dec_o=1 on every beat.
REQ-022 POP order SHALL be ascending: R0 up to R7, then PC (mask bit 8) last. uop_load_o=1 and sp_inc_o=1 on every beat.
REQ-023 In ISSUE, uop_valid_o SHALL be 1, and uop_reg_o SHALL be the priority-selected pending register for the latched direction.
REQ-024 uop_reg_o and the uop/sp flags SHALL remain stable while uop_ready_i=0.
REQ-025 A beat SHALL complete only on uop_valid_o=1 and uop_ready_i=1. On completion the selected mask bit SHALL be cleared; if the mask becomes zero the next state SHALL be DONE, else ISSUE continues with the next register without a gap cycle.
REQ-026 In DONE, done_o SHALL be 1 for exactly one cycle with all uop outputs 0, and the next state SHALL be IDLE. A new push/pop SHALL be accepted only from IDLE.
REQ-027 sp_dec_o, sp_inc_o, uop_load_o and uop_store_o SHALL be 0 whenever uop_valid_o=0.
REQ-028 The beats of a sequence SHALL number popcount(mask), from 0 to 9.
REQ-029 flush_i=1 in any state SHALL force IDLE and clear the mask on the next edge, with no done_o. flush_i SHALL take priority over a simultaneous handshake, whose beat is discarded and not counted. In IDLE with flush_i=1, no instruction SHALL be accepted.
REQ-030 An empty list with R=0 (e.g. 16'hB400) SHALL produce no beats: DONE in the next cycle, then IDLE.

Reset
REQ-031 While rst_n_i=0 the block SHALL force state=IDLE, mask=0 and latched L=0, independent of clk_i.
REQ-032 While rst_n_i=0 every output SHALL be 0: stall_o, uop_valid_o, uop_load_o, uop_store_o, uop_reg_o=4'h0, sp_dec_o, sp_inc_o and done_o.
REQ-033 When reset is asserted mid-sequence, the remaining beats SHALL be abandoned with no done_o. After deassertion the block SHALL accept a new instruction on the first clock edge.

Verification
REQ-034 PUSH {R0,R2,LR} (16'hB505), uop_ready_i=1 -> beats: reg 14, reg 2, reg 0, each with store=1 and sp_dec=1, on consecutive cycles; done_o in the 4th cycle after acceptance; stall_o high from the accept cycle through DONE.
REQ-035 POP {R1,PC} (16'hBD02) -> beats: reg 1, then reg 15, each with load=1 and sp_inc=1; done_o in the following cycle.
REQ-036 16'hB410 with uop_ready_i=0 for 3 cycles -> uop_valid_o=1, reg=4 and sp_dec_o=1 all held for 3 cycles; the beat completes on the 4th cycle when ready rises.
REQ-037 16'hB4FF with flush_i=1 during the 3rd beat (reg 5) with ready=1 -> IDLE next cycle, no done_o, stall_o=0, no further beats.
REQ-038 16'hBCFF with rst_n_i pulsed low during beat 2 (reg 1) -> all outputs 0 immediately; after release, 16'hB400 yields DONE then IDLE with zero beats.
REQ-039 16'hB080 (SP adjust) and 16'h2005 (MOV immediate) with instr_valid_i=1 -> stall_o=0 and no beats.

Source files
------------

// File: rtl/push_pop_sequencer.sv
// Push/pop micro-op sequencer: expands a Thumb PUSH/POP register list into one
// register transfer per beat, with stall and completion handshakes toward decode.
module push_pop_sequencer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        uop_ready_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        uop_valid_o,
    output logic        uop_load_o,
    output logic        uop_store_o,
    output logic [3:0]  uop_reg_o,
    output logic        sp_dec_o,
    output logic        sp_inc_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [8:0]  mask_r;
    logic [8:0]  mask_s;
    logic        pop_r;
    logic        pop_s;
    logic        is_pp_s;
    logic [3:0]  sel_idx_s;
    logic [8:0]  sel_bit_s;

    // Pending-mask index served next: highest bit for PUSH, lowest bit for POP.
    function automatic logic [3:0] pick_idx(input logic [8:0] mask, input logic pop);
        logic [3:0] idx;
        idx = 4'd0;
        if (pop) begin
            for (int i = 8; i >= 0; i--) begin
                if (mask[i]) begin
                    idx = 4'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int i = 0; i <= 8; i++) begin
                if (mask[i]) begin
                    idx = 4'(i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    // Mask bit 8 stands for LR on a push and PC on a pop.
    function automatic logic [3:0] idx_to_reg(input logic [3:0] idx, input logic pop);
        logic [3:0] r;
        if (idx == 4'd8) begin
            r = pop ? 4'd15 : 4'd14;
        end else begin
            r = idx;
        end
        return r;
    endfunction

    assign is_pp_s   = instr_valid_i && (instr_i[15:12] == 4'b1011) && (instr_i[10:9] == 2'b10);
    assign sel_idx_s = pick_idx(mask_r, pop_r);
    assign sel_bit_s = 9'd1 << sel_idx_s;

    // State, pending mask and direction registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            mask_r  <= 9'd0;
            pop_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            mask_r  <= mask_s;
            pop_r   <= pop_s;
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle.
    always_comb begin
        state_s = state_r;
        mask_s  = mask_r;
        pop_s   = pop_r;
        if (flush_i) begin
            state_s = ST_IDLE;
            mask_s  = 9'd0;
            pop_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_pp_s) begin
                        pop_s  = instr_i[11];
                        mask_s = {instr_i[8], instr_i[7:0]};
                        if ({instr_i[8], instr_i[7:0]} != 9'd0) begin
                            state_s = ST_ISSUE;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (uop_ready_i) begin
                        mask_s = mask_r & ~sel_bit_s;
                        if ((mask_r & ~sel_bit_s) == 9'd0) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_ISSUE;
                        end
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    mask_s  = 9'd0;
                    pop_s   = 1'b0;
                end
            endcase
        end
    end

    // Output decode; the IDLE stall is gated by reset since it looks at instr_i.
    always_comb begin
        stall_o     = 1'b0;
        uop_valid_o = 1'b0;
        uop_load_o  = 1'b0;
        uop_store_o = 1'b0;
        uop_reg_o   = 4'd0;
        sp_dec_o    = 1'b0;
        sp_inc_o    = 1'b0;
        done_o      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_o = rst_n_i && is_pp_s && !flush_i;
            end
            ST_ISSUE: begin
                stall_o     = 1'b1;
                uop_valid_o = 1'b1;
                uop_load_o  = pop_r;
                uop_store_o = !pop_r;
                sp_inc_o    = pop_r;
                sp_dec_o    = !pop_r;
                uop_reg_o   = idx_to_reg(sel_idx_s, pop_r);
            end
            ST_DONE: begin
                stall_o = 1'b1;
                done_o  = 1'b1;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Scoreboard bench for push_pop_sequencer: stimulus queues expected beats computed
// from the instruction's register list; a negedge monitor consumes them.
module tb_push_pop_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] instr_i;
    logic        instr_valid_i;
    logic        uop_ready_i;
    logic        flush_i;
    logic        stall_o;
    logic        uop_valid_o;
    logic        uop_load_o;
    logic        uop_store_o;
    logic [3:0]  uop_reg_o;
    logic        sp_dec_o;
    logic        sp_inc_o;
    logic        done_o;

    typedef struct packed {
        logic       load;
        logic [3:0] r;
    } beat_t;

    beat_t beat_q[$];
    int    done_cnt = 0;
    int    checks   = 0;
    int    failures = 0;

    logic [15:0] act_vec;
    logic [15:0] exp_vec;
    bit          acc;
    bit          busy;
    beat_t       fb;

    always #5 clk_i = ~clk_i;

    push_pop_sequencer dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .uop_ready_i   (uop_ready_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .uop_valid_o   (uop_valid_o),
        .uop_load_o    (uop_load_o),
        .uop_store_o   (uop_store_o),
        .uop_reg_o     (uop_reg_o),
        .sp_dec_o      (sp_dec_o),
        .sp_inc_o      (sp_inc_o),
        .done_o        (done_o)
    );

    function automatic bit is_pp(input logic v, input logic [15:0] ins);
        return v && (ins[15:12] == 4'hB) && (ins[10:9] == 2'b10);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard once per cycle.
    always @(negedge clk_i) begin
        act_vec = {7'd0, uop_valid_o, uop_load_o, uop_store_o, sp_inc_o, sp_dec_o, uop_reg_o};
        if (!rst_n_i) begin
            chk("reset_outputs", {act_vec[15:1], stall_o | done_o}, 16'd0);
            chk("reset_uop", act_vec, 16'd0);
            beat_q.delete();
            done_cnt = 0;
        end else begin
            acc  = is_pp(instr_valid_i, instr_i);
            busy = (beat_q.size() != 0) || (done_cnt != 0);
            chk("stall", {15'd0, stall_o}, {15'd0, busy});
            if (acc) begin
                chk("accept_no_uop", act_vec, 16'd0);
                chk("accept_no_done", {15'd0, done_o}, 16'd0);
            end else if (beat_q.size() != 0) begin
                fb      = beat_q[0];
                exp_vec = {7'd0, 1'b1, fb.load, ~fb.load, fb.load, ~fb.load, fb.r};
                chk("beat", act_vec, exp_vec);
                chk("beat_no_done", {15'd0, done_o}, 16'd0);
                if (uop_ready_i && !flush_i) begin
                    void'(beat_q.pop_front());
                end
            end else if (done_cnt != 0) begin
                chk("done_pulse", {15'd0, done_o}, 16'd1);
                chk("done_no_uop", act_vec, 16'd0);
                done_cnt--;
            end else begin
                chk("idle_uop", act_vec, 16'd0);
                chk("idle_done", {15'd0, done_o}, 16'd0);
            end
            if (flush_i) begin
                beat_q.delete();
                done_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // abort_kind: 0 none, 1 flush, 2 reset pulse; abort_at counts cycles after accept-1.
    task automatic send(input logic [15:0] ins, input int pct, input int hold,
                        input int abort_kind, input int abort_at);
        int  k;
        bit  aborted;
        instr_i       = ins;
        instr_valid_i = 1'b1;
        if (is_pp(1'b1, ins)) begin
            if (!ins[11]) begin
                if (ins[8]) beat_q.push_back({1'b0, 4'd14});
                for (int i = 7; i >= 0; i--) if (ins[i]) beat_q.push_back({1'b0, 4'(i)});
            end else begin
                for (int i = 0; i <= 7; i++) if (ins[i]) beat_q.push_back({1'b1, 4'(i)});
                if (ins[8]) beat_q.push_back({1'b1, 4'd15});
            end
            done_cnt++;
        end
        tick();
        instr_valid_i = 1'b0;
        instr_i       = 16'($urandom);
        k       = 0;
        aborted = 1'b0;
        while (((beat_q.size() != 0) || (done_cnt != 0)) && (k < 300) && !aborted) begin
            if (hold >= 0) uop_ready_i = (k >= hold);
            else           uop_ready_i = ($urandom_range(0, 99) < pct);
            if (abort_kind == 1 && k == abort_at) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                aborted = 1'b1;
            end else if (abort_kind == 2 && k == abort_at) begin
                rst_n_i = 1'b0;
                tick();
                rst_n_i = 1'b1;
                aborted = 1'b1;
            end else begin
                tick();
            end
            k++;
        end
        if (k >= 300) begin
            chk("seq_timeout", 16'd1, 16'd0);
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
        end
        if (aborted && abort_kind == 1) begin
            tick();
        end
    endtask

    initial begin
        logic [15:0] ins;
        int          kind;
        rst_n_i       = 1'b0;
        instr_i       = 16'hB505;
        instr_valid_i = 1'b1;
        uop_ready_i   = 1'b1;
        flush_i       = 1'b0;
        tick();
        tick();
        instr_valid_i = 1'b0;
        rst_n_i       = 1'b1;

        send(16'hB505, 100, -1, 0, 0);
        send(16'hBD02, 100, -1, 0, 0);
        send(16'hB410, 100, 3, 0, 0);
        send(16'hB4FF, 100, -1, 1, 2);
        send(16'hBCFF, 100, -1, 2, 1);
        send(16'hB400, 100, -1, 0, 0);
        send(16'hB080, 100, -1, 0, 0);
        send(16'h2005, 100, -1, 0, 0);
        send(16'hBC00, 100, -1, 0, 0);
        send(16'hBDFF, 50, -1, 0, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                ins = {4'hB, 1'($urandom), 2'b10, 1'($urandom), 8'($urandom)};
                if ($urandom_range(0, 7) == 0) ins[7:0] = 8'd0;
            end else begin
                ins = 16'($urandom);
                while (is_pp(1'b1, ins)) ins = 16'($urandom);
            end
            kind = $urandom_range(0, 19);
            if (kind < 2)      send(ins, $urandom_range(30, 100), -1, 1, $urandom_range(0, 6));
            else if (kind < 3) send(ins, $urandom_range(30, 100), -1, 2, $urandom_range(0, 6));
            else               send(ins, $urandom_range(30, 100), -1, 0, 0);
        end
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
